// File: rtl/frame_gen.sv
// -----------------------------------------------------------------------------
// frame_gen -- binary test-pattern video timing generator.
//
// Produces one frame (or back-to-back frames when Continuous=1) made of
// HEIGHT lines. Each line is LSYNC (1 cycle), ACTIVE (WIDTH cycles) and
// HBLANK (HBLANK cycles). Each frame is FSYNC (1 cycle), the lines, and then
// VBLANK (VBLANK cycles). Frame length = 1 + HEIGHT*(1+WIDTH+HBLANK) + VBLANK.
// In ACTIVE the pixel is a diagonal (x==y) OR a vertical line (x==COLUMN).
//
// Optional feature: define FRAME_GEN_NOISE_EN to OR a 16-bit LFSR noise term
// (taps 16,14,13,11, seed 16'hACE1) into Pixel. The LFSR advances once per
// ACTIVE cycle and is only reseeded by reset.
//
// Ports:
//   Clk         in   system clock, rising edge
//   nReset      in   asynchronous active-low reset
//   Start       in   request one frame (sampled only in IDLE)
//   Continuous  in   repeat frames (sampled only in the last frame cycle)
//   Pixel       out  registered pixel value, 0 outside ACTIVE
//   Frame       out  one-cycle start-of-frame strobe (FSYNC)
//   Line        out  one-cycle start-of-line strobe (LSYNC)
//   Busy        out  high whenever the state is not IDLE
//   FrameCount  out  Frame strobes issued, modulo 256
//   o_dbg_state out  current FSM state encoding (debug)
//
// Request semantics: Start is a level sampled on each rising edge while the
// block is IDLE; the first edge with Start=1 launches a frame and Busy rises
// on that same edge. While Busy=1, Start is ignored and never queued.
// -----------------------------------------------------------------------------
module frame_gen #(
  parameter int WIDTH  = 64,
  parameter int HEIGHT = 48,
  parameter int HBLANK = 4,
  parameter int VBLANK = 8,
  parameter int COLUMN = 16
) (
  input  logic       Clk,
  input  logic       nReset,
  input  logic       Start,
  input  logic       Continuous,
  output logic       Pixel,
  output logic       Frame,
  output logic       Line,
  output logic       Busy,
  output logic [7:0] FrameCount,
  output logic [2:0] o_dbg_state
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FSYNC  = 3'd1,
    ST_LSYNC  = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_HBLANK = 3'd4,
    ST_VBLANK = 3'd5
  } state_t;

  localparam logic [15:0] LP_X_LAST = 16'(WIDTH - 1);
  localparam logic [15:0] LP_Y_LAST = 16'(HEIGHT - 1);
  localparam logic [15:0] LP_H_LAST = 16'(HBLANK - 1);
  localparam logic [15:0] LP_V_LAST = 16'(VBLANK - 1);
  localparam logic [15:0] LP_COL    = 16'(COLUMN);

  state_t      r_state;
  logic [15:0] r_x;
  logic [15:0] r_y;
  logic [15:0] r_cnt;   // shared blanking counter (HBLANK and VBLANK)

  state_t      w_state_nxt;
  logic [15:0] w_x_nxt;
  logic [15:0] w_y_nxt;
  logic [15:0] w_cnt_nxt;
  logic        w_line_end;
  logic        w_frame_end;
  logic        w_pattern;
  logic        w_noise;

  assign o_dbg_state = r_state;

  // Next-state and next-counter values. Outputs are registered from these so
  // every strobe lines up with the state it belongs to.
  always_comb begin
    w_state_nxt = r_state;
    w_x_nxt     = r_x;
    w_y_nxt     = r_y;
    w_cnt_nxt   = r_cnt;
    w_line_end  = 1'b0;
    w_frame_end = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (Start) begin
          w_state_nxt = ST_FSYNC;
          w_x_nxt     = '0;
          w_y_nxt     = '0;
          w_cnt_nxt   = '0;
        end
      end
      ST_FSYNC: begin
        w_state_nxt = ST_LSYNC;
        w_x_nxt     = '0;
        w_y_nxt     = '0;
      end
      ST_LSYNC: begin
        w_state_nxt = ST_ACTIVE;
        w_x_nxt     = '0;
      end
      ST_ACTIVE: begin
        if (r_x == LP_X_LAST) begin
          if (HBLANK > 0) begin
            w_state_nxt = ST_HBLANK;
            w_cnt_nxt   = '0;
          end else begin
            w_line_end = 1'b1;
          end
        end else begin
          w_x_nxt = r_x + 16'd1;
        end
      end
      ST_HBLANK: begin
        if (r_cnt == LP_H_LAST) w_line_end = 1'b1;
        else                    w_cnt_nxt  = r_cnt + 16'd1;
      end
      ST_VBLANK: begin
        if (r_cnt == LP_V_LAST) w_frame_end = 1'b1;
        else                    w_cnt_nxt   = r_cnt + 16'd1;
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    if (w_line_end) begin
      if (r_y < LP_Y_LAST) begin
        w_y_nxt     = r_y + 16'd1;
        w_state_nxt = ST_LSYNC;
      end else if (VBLANK > 0) begin
        w_state_nxt = ST_VBLANK;
        w_cnt_nxt   = '0;
      end else begin
        w_frame_end = 1'b1;
      end
    end

    // Continuous only matters here, in the last cycle of a frame.
    if (w_frame_end) begin
      w_state_nxt = Continuous ? ST_FSYNC : ST_IDLE;
      w_x_nxt     = '0;
      w_y_nxt     = '0;
      w_cnt_nxt   = '0;
    end
  end

  assign w_pattern = (w_x_nxt == w_y_nxt) || (w_x_nxt == LP_COL);

`ifdef FRAME_GEN_NOISE_EN
  logic [15:0] r_lfsr;
  logic        w_lfsr_fb;

  assign w_lfsr_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

  // The value held entering an ACTIVE cycle drives that cycle's pixel; the
  // register then steps so each ACTIVE cycle sees a fresh value.
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      r_lfsr <= 16'hACE1;
    end else if (w_state_nxt == ST_ACTIVE) begin
      r_lfsr <= {r_lfsr[14:0], w_lfsr_fb};
    end
  end

  assign w_noise = (r_lfsr[3:0] == 4'h0);
`else
  assign w_noise = 1'b0;
`endif

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      r_state    <= ST_IDLE;
      r_x        <= '0;
      r_y        <= '0;
      r_cnt      <= '0;
      Pixel      <= 1'b0;
      Frame      <= 1'b0;
      Line       <= 1'b0;
      Busy       <= 1'b0;
      FrameCount <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_x     <= w_x_nxt;
      r_y     <= w_y_nxt;
      r_cnt   <= w_cnt_nxt;
      Frame   <= (w_state_nxt == ST_FSYNC);
      Line    <= (w_state_nxt == ST_LSYNC);
      Busy    <= (w_state_nxt != ST_IDLE);
      Pixel   <= (w_state_nxt == ST_ACTIVE) && (w_pattern || w_noise);
      if (w_state_nxt == ST_FSYNC) FrameCount <= FrameCount + 8'd1;
    end
  end

endmodule

// File: tb/tb_frame_gen.sv
// -----------------------------------------------------------------------------
// tb_frame_gen -- scoreboard bench for frame_gen with WIDTH=8, HEIGHT=4,
// HBLANK=2, VBLANK=3, COLUMN=5 (frame length 48 cycles).
// Expected output events (Frame, Line, Pixel strobes and the Busy fall) are
// queued with the cycle they must appear in; a monitor on the falling edge
// pops and compares every event the DUT presents.
// -----------------------------------------------------------------------------
module tb_frame_gen;

  localparam int W    = 8;
  localparam int H    = 4;
  localparam int HB   = 2;
  localparam int VB   = 3;
  localparam int COL  = 5;
  localparam int FLEN = 48;   // 1 + 4*(1+8+2) + 3
  localparam int LLEN = 11;   // 1 + 8 + 2

  localparam logic [3:0] EV_FRAME = 4'd1;
  localparam logic [3:0] EV_LINE  = 4'd2;
  localparam logic [3:0] EV_PIX   = 4'd3;
  localparam logic [3:0] EV_IDLE  = 4'd4;

  logic       Clk;
  logic       nReset;
  logic       Start;
  logic       Continuous;
  logic       Pixel;
  logic       Frame;
  logic       Line;
  logic       Busy;
  logic [7:0] FrameCount;
  logic [2:0] dbg_state;

  frame_gen #(
    .WIDTH (W),
    .HEIGHT(H),
    .HBLANK(HB),
    .VBLANK(VB),
    .COLUMN(COL)
  ) dut (
    .Clk        (Clk),
    .nReset     (nReset),
    .Start      (Start),
    .Continuous (Continuous),
    .Pixel      (Pixel),
    .Frame      (Frame),
    .Line       (Line),
    .Busy       (Busy),
    .FrameCount (FrameCount),
    .o_dbg_state(dbg_state)
  );

  // ---------------- clock / reset / cycle counter ----------------
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [31:0] exp_q[$];
  int          checks   = 0;
  int          failures = 0;
  logic        prev_busy = 1'b0;
  int          pix_cnt  = 0;
  int          exp_fc   = 0;

  // Pixel=1 positions of one frame in time order (x,y).
  int pix_x[8] = '{0, 5, 1, 5, 2, 5, 3, 5};
  int pix_y[8] = '{0, 0, 1, 1, 2, 2, 3, 3};

  function automatic logic [31:0] mk_ev(input logic [3:0] kind, input int c);
    return {kind, 28'(c)};
  endfunction

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic handle_ev(input logic [3:0] kind, input string name);
    logic [31:0] got;
    logic [31:0] want;
    checks++;
    got = mk_ev(kind, cyc);
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL unexpected_%s: got event at cycle %0d, expected none", name, cyc);
    end else begin
      want = exp_q.pop_front();
      if (got !== want) begin
        failures++;
        $display("FAIL event_%s: got kind %0d cycle %0d expected kind %0d cycle %0d",
                 name, got[31:28], got[27:0], want[31:28], want[27:0]);
      end
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge Clk) begin
    if (!nReset) begin
      prev_busy = 1'b0;
    end else begin
      if (Frame) handle_ev(EV_FRAME, "frame");
      if (Line)  handle_ev(EV_LINE, "line");
`ifdef FRAME_GEN_NOISE_EN
      if (Pixel) pix_cnt++;
`else
      if (Pixel) handle_ev(EV_PIX, "pixel");
`endif
      if (prev_busy && !Busy) handle_ev(EV_IDLE, "busy_fall");
      if (Frame && Line) check_eq("frame_line_overlap", {Frame, Line}, 2'b00);
      prev_busy = Busy;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_until(input int t);
    while (cyc < t) begin
      @(posedge Clk);
      #1;
    end
  endtask

  // Returns k, the cycle in which Frame is expected.
  task automatic pulse_start(output int k);
    @(posedge Clk);
    #1;
    Start = 1'b1;
    k = cyc + 1;
    @(posedge Clk);
    #1;
    Start = 1'b0;
  endtask

  task automatic push_frame(input int k);
    exp_q.push_back(mk_ev(EV_FRAME, k));
    for (int y = 0; y < H; y++) begin
      exp_q.push_back(mk_ev(EV_LINE, k + 1 + LLEN * y));
`ifndef FRAME_GEN_NOISE_EN
      for (int p = 0; p < 8; p++) begin
        if (pix_y[p] == y) exp_q.push_back(mk_ev(EV_PIX, k + 2 + LLEN * y + pix_x[p]));
      end
`endif
    end
    exp_fc = (exp_fc + 1) % 256;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_pixel"}, 32'(Pixel), 32'd0);
    check_eq({tag, "_frame"}, 32'(Frame), 32'd0);
    check_eq({tag, "_line"},  32'(Line),  32'd0);
    check_eq({tag, "_busy"},  32'(Busy),  32'd0);
    check_eq({tag, "_fcount"}, 32'(FrameCount), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int k;
    int busy_hits;
    nReset     = 1'b0;
    Start      = 1'b0;
    Continuous = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    check_reset_outputs("reset");
    nReset = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    check_eq("idle_after_reset_busy", 32'(Busy), 32'd0);

    // Single frame: strobes, pixel positions, 48-cycle Busy, FrameCount.
    pix_cnt = 0;
    pulse_start(k);
    push_frame(k);
    exp_q.push_back(mk_ev(EV_IDLE, k + FLEN));
    wait_until(k + FLEN + 2);
    check_eq("single_fcount", 32'(FrameCount), 32'(exp_fc));
    check_eq("single_drained", 32'(exp_q.size()), 32'd0);
    check_eq("single_busy_end", 32'(Busy), 32'd0);
`ifdef FRAME_GEN_NOISE_EN
    check_eq("noise_pix_min", 32'(pix_cnt >= 8), 32'd1);
`endif

    // Start pulsed during line 2 must be ignored.
    pulse_start(k);
    push_frame(k);
    exp_q.push_back(mk_ev(EV_IDLE, k + FLEN));
    wait_until(k + 1 + 2 * LLEN + 3);
    Start = 1'b1;
    @(posedge Clk);
    #1;
    Start = 1'b0;
    wait_until(k + FLEN + 4);
    check_eq("ignored_fcount", 32'(FrameCount), 32'(exp_fc));
    check_eq("ignored_drained", 32'(exp_q.size()), 32'd0);
    check_eq("ignored_busy_end", 32'(Busy), 32'd0);

    // Reset during ACTIVE of line 1.
    pulse_start(k);
    push_frame(k);
    wait_until(k + 15);
    check_eq("pre_reset_busy", 32'(Busy), 32'd1);
    nReset = 1'b0;
    #1;
    check_reset_outputs("midframe_reset");
    exp_q.delete();
    exp_fc = 0;
    repeat (2) @(posedge Clk);
    #1;
    nReset = 1'b1;
    busy_hits = 0;
    repeat (20) begin
      @(negedge Clk);
      if (Busy) busy_hits++;
    end
    check_eq("post_reset_busy_hits", 32'(busy_hits), 32'd0);
    check_eq("post_reset_fcount", 32'(FrameCount), 32'd0);
    @(posedge Clk);
    #1;

    // Continuous: 256 frames back-to-back, FrameCount wraps to 0.
    Continuous = 1'b1;
    pulse_start(k);
    for (int n = 0; n < 256; n++) push_frame(k + FLEN * n);
    exp_q.push_back(mk_ev(EV_IDLE, k + FLEN * 256));
    wait_until(k + 5);
    check_eq("cont_fcount_first", 32'(FrameCount), 32'd1);
    wait_until(k + FLEN + 5);
    check_eq("cont_fcount_second", 32'(FrameCount), 32'd2);
    wait_until(k + FLEN * 255 + 10);
    Continuous = 1'b0;
    wait_until(k + FLEN * 256 + 3);
    check_eq("cont_fcount_wrap", 32'(FrameCount), 32'(exp_fc));
    check_eq("cont_fcount_zero", 32'(FrameCount), 32'd0);
    check_eq("cont_drained", 32'(exp_q.size()), 32'd0);
    check_eq("cont_busy_end", 32'(Busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
